// File: rtl/shift_unpack_rx.sv
// Restores left-shifted words (LSB marker must be 0) with a right shift and buffers them in a FIFO.
// Latency: accept -> FIFO write 3 edges later; stalls in S_PUSH while the FIFO is full and not popping.
module shift_unpack_rx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     fmt_err,
  output logic [ERR_W-1:0]         err_count,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SHIFT, S_PUSH} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [ERR_W-1:0] r_err_cnt;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = (r_count != '0) && out_ready;
  // A pop in the same cycle frees the slot the push lands in (wr_ptr == rd_ptr when full).
  assign w_push = (r_state == S_PUSH) && (!w_full || w_pop);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_CHECK;
      S_CHECK: w_next = S_SHIFT;
      S_SHIFT: w_next = S_PUSH;
      S_PUSH:  if (w_push) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cap     <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_state <= w_next;

      if (r_state == S_IDLE && in_valid) r_cap <= in_data;
      else if (r_state == S_SHIFT)       r_cap <= {1'b0, r_cap[WIDTH-1:1]};

      if (r_state == S_CHECK && r_cap[0] && r_err_cnt != '1)
        r_err_cnt <= r_err_cnt + ERR_W'(1);

      if (w_push) begin
        r_mem[r_wr_ptr] <= r_cap;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign fmt_err    = (r_state == S_CHECK) && r_cap[0];
  assign out_valid  = (r_count != '0);
  assign out_data   = r_mem[r_rd_ptr];
  assign err_count  = r_err_cnt;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_shift_unpack_rx.sv
// Directed bench for shift_unpack_rx: table of single-word vectors plus FIFO-full, saturation and reset sequences.
module tb_shift_unpack_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, fmt_err;
  logic [7:0] out_data, err_count;
  logic [2:0] fifo_count;

  logic       in_ready2, out_valid2, fmt_err2;
  logic [7:0] out_data2;
  logic [1:0] err_count2;
  logic [2:0] fifo_count2;

  shift_unpack_rx u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fmt_err(fmt_err), .err_count(err_count), .fifo_count(fifo_count)
  );

  shift_unpack_rx #(.WIDTH(8), .DEPTH(4), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .fmt_err(fmt_err2), .err_count(err_count2), .fifo_count(fifo_count2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
    logic       err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Returns at the negedge after the accepting edge (DUT is then in S_CHECK).
  task automatic push_word(input logic [7:0] d);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step;
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
    chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
    chk("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_err_count",  {24'd0, err_count},  32'd0);
    chk("rst_fmt_err",    {31'd0, fmt_err},    32'd0);
    chk("rst_out_data",   {24'd0, out_data},   32'd0);
  endtask

  initial begin
    int exp_err;
    int pulses2;
    logic [7:0] w;

    vecs[0] = '{din: 8'hA4, dout: 8'h52, err: 1'b0};
    vecs[1] = '{din: 8'h0B, dout: 8'h05, err: 1'b1};
    vecs[2] = '{din: 8'hFF, dout: 8'h7F, err: 1'b1};
    vecs[3] = '{din: 8'h80, dout: 8'h40, err: 1'b0};
    vecs[4] = '{din: 8'h01, dout: 8'h00, err: 1'b1};
    vecs[5] = '{din: 8'hFE, dout: 8'h7F, err: 1'b0};

    @(negedge clk);
    do_reset;

    // Single words through an empty FIFO with the consumer always ready
    out_ready = 1'b1;
    exp_err = 0;
    for (int i = 0; i < 6; i++) begin
      push_word(vecs[i].din);
      chk("vec_fmt_err",      {31'd0, fmt_err},  {31'd0, vecs[i].err});
      chk("vec_busy",         {31'd0, in_ready}, 32'd0);
      if (vecs[i].err) exp_err++;
      step;
      chk("vec_fmt_err_off",  {31'd0, fmt_err},   32'd0);
      chk("vec_err_count",    {24'd0, err_count}, exp_err);
      step;
      chk("vec_not_yet",      {31'd0, out_valid}, 32'd0);
      step;
      chk("vec_out_valid",    {31'd0, out_valid}, 32'd1);
      chk("vec_out_data",     {24'd0, out_data},  {24'd0, vecs[i].dout});
      chk("vec_fifo_count",   {29'd0, fifo_count}, 32'd1);
      step;
      chk("vec_popped",       {31'd0, out_valid}, 32'd0);
    end

    // Fill the FIFO and stall the fifth word in S_PUSH
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      w = 8'(2 * k);
      push_word(w);
    end
    step; step; step;
    chk("full_count",    {29'd0, fifo_count}, 32'd4);
    chk("full_in_ready", {31'd0, in_ready},   32'd0);
    chk("full_head",     {24'd0, out_data},   32'h01);
    step;
    chk("stall_in_ready", {31'd0, in_ready},   32'd0);
    chk("stall_count",    {29'd0, fifo_count}, 32'd4);

    // One-cycle pop while full: the pending word goes in on the same edge
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    chk("pulse_count",    {29'd0, fifo_count}, 32'd4);
    chk("pulse_in_ready", {31'd0, in_ready},   32'd1);
    chk("pulse_head",     {24'd0, out_data},   32'h02);

    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk("drain_valid", {31'd0, out_valid}, 32'd1);
      chk("drain_data",  {24'd0, out_data},  k);
      step;
    end
    chk("drain_empty", {31'd0, out_valid},  32'd0);
    chk("drain_count", {29'd0, fifo_count}, 32'd0);

    // Error counter saturation on the 2-bit instance
    do_reset;
    out_ready = 1'b1;
    pulses2 = 0;
    for (int k = 0; k < 5; k++) begin
      w = 8'(2 * k + 1);
      push_word(w);
      chk("sat_fmt_err", {31'd0, fmt_err}, 32'd1);
      if (fmt_err2) pulses2++;
      step;
      chk("sat_err_count2", {30'd0, err_count2}, (k + 1 > 3) ? 3 : k + 1);
      chk("sat_err_count8", {24'd0, err_count},  k + 1);
    end
    chk("sat_pulses2", pulses2, 5);

    // Reset with two buffered words and a third in S_SHIFT
    do_reset;
    out_ready = 1'b0;
    push_word(8'h10);
    push_word(8'h20);
    push_word(8'h31);
    step;
    chk("mid_count_pre", {29'd0, fifo_count}, 32'd2);
    chk("mid_err_pre",   {24'd0, err_count},  32'd1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("mid_count",     {29'd0, fifo_count}, 32'd0);
    chk("mid_out_valid", {31'd0, out_valid},  32'd0);
    chk("mid_err_count", {24'd0, err_count},  32'd0);
    chk("mid_in_ready",  {31'd0, in_ready},   32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("mid_no_output", {31'd0, out_valid}, 32'd0);
      chk("mid_no_err",    {31'd0, fmt_err},   32'd0);
      step;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
